// File: rtl/parity_pkg.sv
// Shared constants and FSM state type for the parity frame checker.
package parity_pkg;
   localparam int DATA_W    = 7;
   localparam int FRAME_W   = DATA_W + 1;
   localparam int ERR_CNT_W = 8;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      CHECK   = 2'd1,
      OUTPUT  = 2'd2
   } state_t;
endpackage

// File: rtl/parity_frame_checker_if.sv
// Serial bit input and checked-word output handshakes of the frame checker.
interface parity_frame_checker_if #(
   parameter int DATA_W = parity_pkg::DATA_W
);
   logic              bit_in;
   logic              bit_valid;
   logic              bit_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_err;
   logic              out_valid;
   logic              out_ready;

   modport slave (
      input  bit_in, bit_valid, out_ready,
      output bit_ready, out_data, out_err, out_valid
   );

   modport master (
      output bit_in, bit_valid, out_ready,
      input  bit_ready, out_data, out_err, out_valid
   );
endinterface

// File: rtl/parity_frame_checker.sv
// Deserialises LSB-first frames, checks the received parity bit against the
// external parity stage result F, and reports each word with an error count.
module parity_frame_checker #(
   parameter int DATA_W    = parity_pkg::DATA_W,
   parameter int ERR_CNT_W = parity_pkg::ERR_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   parity_frame_checker_if.slave bus,
   output logic [DATA_W-1:0]    D,
   input  logic                 F,
   input  logic                 cnt_clr,
   output logic [ERR_CNT_W-1:0] err_count
);
   import parity_pkg::*;

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] PAR_IDX = CNT_W'(DATA_W);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] bit_cnt;
   logic             rx_par;
   logic             accept;
   logic             mismatch;

   assign bus.bit_ready = (state == COLLECT) && !rst;
   assign accept        = bus.bit_valid && bus.bit_ready;
   assign mismatch      = F ^ rx_par;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= COLLECT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (accept && bit_cnt == PAR_IDX) state_nxt = CHECK;
         CHECK:   state_nxt = OUTPUT;
         OUTPUT:  if (bus.out_ready) state_nxt = COLLECT;
         default: state_nxt = COLLECT;
      endcase
   end

   // D only changes on accepted data bits, so F has settled by CHECK.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt       <= '0;
         D             <= '0;
         rx_par        <= 1'b0;
         bus.out_data  <= '0;
         bus.out_err   <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (accept) begin
                  if (bit_cnt == PAR_IDX) begin
                     rx_par  <= bus.bit_in;
                     bit_cnt <= '0;
                  end else begin
                     D[bit_cnt] <= bus.bit_in;
                     bit_cnt    <= bit_cnt + 1'b1;
                  end
               end
            end
            CHECK: begin
               bus.out_data  <= D;
               bus.out_err   <= mismatch;
               bus.out_valid <= 1'b1;
            end
            OUTPUT: if (bus.out_ready) bus.out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

   // Clear takes priority over a coincident increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_count <= '0;
      else if (cnt_clr)
         err_count <= '0;
      else if (state == CHECK && mismatch && !(&err_count))
         err_count <= err_count + 1'b1;
   end
endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench: expected words queued as frames are sent, checked on handshake.
module tb_parity_frame_checker;
   localparam int DW = 7;
   localparam int CW = 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] d;
   logic          f;
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] err_count;

   int   n_chk  = 0;
   int   n_pass = 0;
   int   model_cnt = 0;
   exp_t sb[$];

   parity_frame_checker_if #(.DATA_W(DW)) bus();

   parity_frame_checker #(.DATA_W(DW), .ERR_CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .D         (d),
      .F         (f),
      .cnt_clr   (cnt_clr),
      .err_count (err_count)
   );

   assign f = ^d;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
   endtask

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_data", 32'(bus.out_data), 32'(e.data));
            chk("sb_err", 32'(bus.out_err), 32'(e.err));
         end
      end
   end

   // Called and returns at a negedge; bit accepted at the posedge in between.
   task automatic send_bit(input logic b);
      int n = 0;
      bus.bit_in    = b;
      bus.bit_valid = 1'b1;
      while (!bus.bit_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("bit_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      bus.bit_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [DW-1:0] data, input logic par,
                             input bit gap, input bit clr);
      exp_t e;
      logic err;
      err    = (^data) ^ par;
      e.data = data;
      e.err  = err;
      sb.push_back(e);
      if (clr) model_cnt = 0;
      else if (err && model_cnt < 255) model_cnt++;
      for (int i = 0; i < DW; i++) begin
         send_bit(data[i]);
         if (gap) @(negedge clk);
      end
      send_bit(par);
      if (clr) cnt_clr = 1'b1;
      chk("valid_in_check", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      cnt_clr = 1'b0;
      chk("valid_latency", 32'(bus.out_valid), 32'd1);
      chk("err_count", 32'(err_count), 32'(model_cnt));
   endtask

   initial begin
      bus.bit_in    = 1'b0;
      bus.bit_valid = 1'b0;
      bus.out_ready = 1'b1;
      #12;
      chk("rst_bit_ready", 32'(bus.bit_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_d", 32'(d), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("bit_ready_after_rst", 32'(bus.bit_ready), 32'd1);

      // good then bad frame
      send_frame(7'h53, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      send_frame(7'h53, 1'b1, 1'b0, 1'b0);
      @(negedge clk);

      // backpressure on a bad frame
      @(posedge clk); #1 bus.out_ready = 1'b0;
      @(negedge clk);
      send_frame(7'h2C, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_data", 32'(bus.out_data), 32'h2C);
         chk("bp_err", 32'(bus.out_err), 32'd1);
         chk("bp_bit_ready", 32'(bus.bit_ready), 32'd0);
      end
      @(posedge clk); #1 bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_release_ready", 32'(bus.bit_ready), 32'd1);

      // gapped input
      send_frame(7'h7F, 1'b1, 1'b1, 1'b0);
      @(negedge clk);

      // saturation, then clear coinciding with a bad frame's CHECK
      for (int k = 0; k < 257; k++) begin
         send_frame(7'(k), ~(^7'(k)), 1'b0, 1'b0);
         @(negedge clk);
      end
      chk("sat_count", 32'(err_count), 32'd255);
      send_frame(7'h11, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("clr_count", 32'(err_count), 32'd0);

      // reset mid-frame
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_d", 32'(d), 32'd0);
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_ready", 32'(bus.bit_ready), 32'd0);
      chk("mid_rst_data", 32'(bus.out_data), 32'd0);
      chk("mid_rst_err", 32'(bus.out_err), 32'd0);
      chk("mid_rst_cnt", 32'(err_count), 32'd0);
      model_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send_frame(7'h01, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Upstream and downstream wrapper for the combinational 7-bit parity stage (D[6:0] -> F).
- Deserialises an LSB-first bit stream into 8-bit frames: 7 data bits, then 1 received parity bit.
- Drives the 7 data bits to the parity stage as D, samples its F, and compares F with the received parity bit.
- Emits each checked word through a valid/ready handshake and keeps a saturating error count.

Parameters:
- DATA_W, 7, data bits per frame; must match the width of the parity stage.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_in  input  1  serial data; LSB first, parity bit last.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  block accepts a bit this cycle.
- D  output  DATA_W  assembled data word, drives the parity stage input.
- F  input  1  parity-stage result; combinational from D.
- out_data  output  DATA_W  checked data word.
- out_err  output  1  1 when F != received parity bit.
- out_valid  output  1  out_data/out_err valid.
- out_ready  input  1  downstream accepts the output.
- cnt_clr  input  1  synchronous clear of err_count.
- err_count  output  ERR_CNT_W  number of errored frames, saturating.

Behaviour:
- Reset (async, rst=1) values:
  - state=COLLECT, bit_cnt=0, D=0, rx_par=0.
  - out_data=0, out_err=0, out_valid=0, err_count=0.
  - bit_ready=0 while rst=1; bit_ready=1 in the first cycle after release.
- States: COLLECT, CHECK, OUTPUT. All outputs are registered except bit_ready, which equals (state==COLLECT) && !rst.
- Bit acceptance: a bit is accepted when bit_valid && bit_ready.
- COLLECT:
  - Accepted bit with bit_cnt<DATA_W: write D[bit_cnt] <= bit_in, then bit_cnt++.
  - Accepted bit with bit_cnt==DATA_W: rx_par <= bit_in, bit_cnt <= 0, next state CHECK.
  - Cycles with bit_valid=0 are ignored; no timeout.
- D is held stable from acceptance of the last data bit until the next frame's first bit is accepted. F is therefore settled by CHECK.
- CHECK (exactly 1 cycle):
  - out_data <= D, out_err <= F ^ rx_par, out_valid <= 1.
  - If F ^ rx_par = 1 and err_count is not all-ones: err_count++.
  - Next state OUTPUT.
- OUTPUT:
  - Hold out_data, out_err and out_valid until out_ready=1.
  - On the out_ready=1 cycle: out_valid <= 0, next state COLLECT.
  - out_ready while out_valid=0 has no effect.
- Latency: CHECK is the cycle after the parity bit is accepted; out_valid rises one cycle after CHECK. With zero backpressure, minimum frame period = 8 bit cycles + CHECK + 1 OUTPUT cycle = 10 cycles.
- Backpressure: bit_ready=0 in CHECK and OUTPUT. No bits are dropped; the upstream source must hold bit_valid.
- err_count:
  - Saturates at 2^ERR_CNT_W-1.
  - cnt_clr=1 sets it to 0 next cycle.
  - If cnt_clr and an error increment coincide in CHECK, the clear wins: result is 0.
  - cnt_clr does not affect state, D or outputs.
- Reset asserted mid-frame or mid-OUTPUT discards the partial or pending frame immediately (async). The first bit after release is treated as D[0].
- Parity sense (odd/even) is defined solely by the parity stage. This block only compares F with the received bit.

Decomposition:
- Shared package parity_pkg:
  - DATA_W=7, FRAME_W=DATA_W+1, ERR_CNT_W.
  - State enum {COLLECT, CHECK, OUTPUT}.
- One natural sub-module: parity_davio, the existing parity stage. It is instantiated by the integrating top level, not inside this block, and connects D->D and F->F.
- The saturating counter stays inline; it is too small for a separate module.

Test Plan:
- Bench model: F = XOR of D bits, i.e. the parity stage replaced by ^D.
- Good frame: send data 7'b1010011 LSB first, then parity bit 0, with out_ready=1 -> out_valid=1 two cycles after the parity bit is accepted; out_data=7'h53, out_err=0, err_count=0.
- Bad frame: same data, parity bit 1 -> out_err=1, err_count=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data/out_err held constant; bit_ready=0 throughout. out_ready=1 -> out_valid=0 next cycle and bit_ready=1.
- Gapped input: bit_valid toggles 1/0 across a frame of 7'h7F with parity 1 -> out_data=7'h7F, out_err=0; idle cycles cause no shift.
- Saturation and clear: 257 bad frames with ERR_CNT_W=8 -> err_count=255. Then assert cnt_clr in the same cycle as a bad frame's CHECK -> err_count=0.
- Reset mid-frame: assert rst after 4 data bits -> all outputs 0 immediately. Then a full frame of 7'h01 with parity 1 -> out_data=7'h01, out_err=0.
